// File: rtl/uart_tx_pkg.sv
// Shared UART transmit definitions: FSM encoding, line levels, parity helper.
// The PARITY state and helper exist only when UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

  localparam int unsigned MAX_DATA_BITS = 9;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_ACK    = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd5,
`endif
    ST_STOP   = 3'd6
  } txState_e;

`ifdef UART_TX_PARITY_EN
  // Even parity over a zero-extended data word.
  function automatic logic evenParity(input logic [MAX_DATA_BITS-1:0] word);
    return ^word;
  endfunction
`endif

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: bitTick is high on the last clk cycle of each bit period.
// Counter restarts from 0 whenever clear is high; shared with the receiver.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bitTick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BEFORE_END = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt;

  // bitTick is registered: it rises together with cnt reaching LAST_CNT.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt     <= '0;
      bitTick <= 1'b0;
    end else begin
      if (cnt == LAST_CNT) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      bitTick <= (cnt == BEFORE_END);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops the TX Fifo (readReq/readAck) and sends 8N1, LSB first.
// Define UART_TX_PARITY_EN to insert an even parity bit after the data bits.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifoEmpty,
  output logic                 fifoReadReq,
  input  logic                 fifoReadAck,
  input  logic [DATA_BITS-1:0] fifoData,
  output logic                 txd,
  output logic                 busy
);

  localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  txState_e             state;
  txState_e             nextState;
  logic [DATA_BITS-1:0] shiftReg;
  logic [IDX_W-1:0]     bitIdx;
  logic                 bitTick;
  logic                 timerClear;
  logic                 loadWord;
`ifdef UART_TX_PARITY_EN
  logic                 parityBit;
`endif

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) bitTimer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timerClear),
    .bitTick(bitTick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic. A pending word at the end of STOP goes straight to REQ,
  // so consecutive frames are separated by the stop time plus REQ and ACK only.
  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE: begin
        if (!fifoEmpty) nextState = ST_REQ;
      end
      ST_REQ: begin
        nextState = ST_ACK;
      end
      ST_ACK: begin
        nextState = fifoReadAck ? ST_START : ST_IDLE;
      end
      ST_START: begin
        if (bitTick) nextState = ST_DATA;
      end
      ST_DATA: begin
        if (bitTick && (bitIdx == LAST_DATA)) begin
`ifdef UART_TX_PARITY_EN
          nextState = ST_PARITY;
`else
          nextState = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bitTick) nextState = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (bitTick && (bitIdx == LAST_STOP)) begin
          nextState = fifoEmpty ? ST_IDLE : ST_REQ;
        end
      end
      default: begin
        nextState = ST_IDLE;
      end
    endcase
  end

  // Output/control decode: the timer only runs while a bit is on the line.
  always_comb begin
    timerClear = 1'b1;
    loadWord   = 1'b0;
    case (state)
      ST_START,
      ST_DATA,
      ST_STOP: begin
        timerClear = 1'b0;
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        timerClear = 1'b0;
      end
`endif
      ST_ACK: begin
        loadWord = fifoReadAck;
      end
      default: begin
        timerClear = 1'b1;
      end
    endcase
  end

  // Registered handshake/status outputs, decoded one edge ahead from nextState.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifoReadReq <= 1'b0;
      busy        <= 1'b0;
    end else begin
      fifoReadReq <= (nextState == ST_REQ);
      busy        <= (nextState != ST_IDLE);
    end
  end

  // Serial datapath: txd, shift register and bit/stop index.
  always_ff @(posedge clk) begin
    if (rst) begin
      txd      <= IDLE_LEVEL;
      shiftReg <= '0;
      bitIdx   <= '0;
`ifdef UART_TX_PARITY_EN
      parityBit <= 1'b0;
`endif
    end else begin
      case (state)
        ST_ACK: begin
          if (loadWord) begin
            shiftReg <= fifoData;
            txd      <= START_LEVEL;
            bitIdx   <= '0;
`ifdef UART_TX_PARITY_EN
            parityBit <= evenParity(MAX_DATA_BITS'(fifoData));
`endif
          end else begin
            txd <= IDLE_LEVEL;
          end
        end
        ST_START: begin
          if (bitTick) begin
            txd      <= shiftReg[0];
            shiftReg <= shiftReg >> 1;
          end
        end
        ST_DATA: begin
          if (bitTick) begin
            if (bitIdx == LAST_DATA) begin
              bitIdx <= '0;
`ifdef UART_TX_PARITY_EN
              txd    <= parityBit;
`else
              txd    <= IDLE_LEVEL;
`endif
            end else begin
              bitIdx   <= bitIdx + IDX_W'(1);
              txd      <= shiftReg[0];
              shiftReg <= shiftReg >> 1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bitTick) begin
            txd    <= IDLE_LEVEL;
            bitIdx <= '0;
          end
        end
`endif
        ST_STOP: begin
          if (bitTick) begin
            bitIdx <= (bitIdx == LAST_STOP) ? '0 : bitIdx + IDX_W'(1);
          end
        end
        default: begin
          txd <= IDLE_LEVEL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with a small behavioural Fifo, CLKS_PER_BIT=4.
// Define UART_TX_PARITY_EN on both bench and RTL to exercise the parity bit.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned PAR = 1;
`else
  localparam int unsigned PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifoEmpty;
  logic       fifoReadReq;
  logic       fifoReadAck = 1'b0;
  logic [7:0] fifoData = 8'h00;
  logic       txd;
  logic       busy;

  int total = 0;
  int bad   = 0;

  // Behavioural Fifo: push from the stimulus, pop on readReq with a 1-cycle ack.
  logic [7:0]  mem [0:63];
  int unsigned pushCnt = 0;
  int unsigned popCnt  = 0;
  logic        fakeNotEmpty = 1'b0;
  int unsigned reqCount = 0;

  assign fifoEmpty = (pushCnt == popCnt) && !fakeNotEmpty;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifoReadReq && (pushCnt != popCnt)) begin
      fifoReadAck <= 1'b1;
      fifoData    <= mem[popCnt[5:0]];
      popCnt      <= popCnt + 1;
    end else begin
      fifoReadAck <= 1'b0;
    end
    if (fifoReadReq) reqCount <= reqCount + 1;
  end

  uart_tx #(
    .DATA_BITS   (8),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifoEmpty  (fifoEmpty),
    .fifoReadReq(fifoReadReq),
    .fifoReadAck(fifoReadAck),
    .fifoData   (fifoData),
    .txd        (txd),
    .busy       (busy)
  );

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] v);
    mem[pushCnt[5:0]] = v;
    pushCnt = pushCnt + 1;
  endtask

  // Advance on negedges until txd is low (start bit), bounded.
  task automatic waitFall(input string tag);
    int n = 0;
    while (txd !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(32'(txd), 32'd0, tag);
  endtask

  // Called at the first negedge with txd low (j=0); samples every bit mid-period.
  task automatic rxFrame(input logic [7:0] v, input logic expPar, input bit last,
                         input string tag, output int gap);
    gap = 0;
    repeat (2) @(negedge clk);
    check(32'(txd), 32'd0, {tag, " start"});
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      check(32'(txd), 32'(v[i]), $sformatf("%s bit%0d", tag, i));
    end
    if (PAR != 0) begin
      repeat (CPB) @(negedge clk);
      check(32'(txd), 32'(expPar), {tag, " parity"});
    end
    repeat (CPB) @(negedge clk);
    check(32'(txd), 32'd1, {tag, " stop"});
    if (last) begin
      check(32'(busy), 32'd1, {tag, " busy in stop"});
      repeat (2) @(negedge clk);
      check(32'(busy), 32'd0, {tag, " busy after stop"});
      check(32'(txd), 32'd1, {tag, " idle line"});
    end else begin
      gap = 2;
      while (txd === 1'b1 && gap < 40) begin
        gap++;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    int lows;
    int gap;
    int unsigned r0;
    int unsigned p0;

    // 1) reset and idle
    repeat (3) @(negedge clk);
    check(32'(txd), 32'd1, "reset txd");
    check(32'(busy), 32'd0, "reset busy");
    check(32'(fifoReadReq), 32'd0, "reset req");
    rst = 1'b0;
    lows = 0;
    repeat (20) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) lows++;
    end
    check(32'(lows), 32'd0, "idle line/busy");
    check(reqCount, 32'd0, "idle no req");

    // 2) single frame 0xA5
    push(8'hA5);
    @(negedge clk);
    check(32'(fifoReadReq), 32'd1, "A5 req high");
    check(32'(busy), 32'd1, "A5 busy");
    check(32'(txd), 32'd1, "A5 txd in REQ");
    @(negedge clk);
    check(32'(fifoReadReq), 32'd0, "A5 req one cycle");
    check(32'(txd), 32'd1, "A5 txd in ACK");
    @(negedge clk);
    check(32'(txd), 32'd0, "A5 start at edge2");
    rxFrame(8'hA5, 1'b0, 1'b1, "A5", gap);

    // 3) back-to-back 0x00, 0xFF, 0x3C
    r0 = reqCount;
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    waitFall("b2b first start");
    rxFrame(8'h00, 1'b0, 1'b0, "f00", gap);
    check(32'(gap), 32'd6, "gap 00-FF");
    rxFrame(8'hFF, 1'b0, 1'b0, "fFF", gap);
    check(32'(gap), 32'd6, "gap FF-3C");
    rxFrame(8'h3C, 1'b0, 1'b1, "f3C", gap);
    check(reqCount - r0, 32'd3, "b2b pops");
    check(32'(fifoEmpty), 32'd1, "b2b fifo empty");

    // 4) reset mid-frame, then a clean frame
    push(8'h55);
    waitFall("55 start");
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check(32'(txd), 32'd1, "abort txd");
    check(32'(busy), 32'd0, "abort busy");
    check(32'(fifoReadReq), 32'd0, "abort req");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check(32'(txd), 32'd1, "abort stays idle");
    push(8'h81);
    waitFall("81 start");
    rxFrame(8'h81, 1'b0, 1'b1, "f81", gap);

`ifdef UART_TX_PARITY_EN
    // 5) parity values
    push(8'h07);
    waitFall("07 start");
    rxFrame(8'h07, 1'b1, 1'b1, "f07", gap);
    push(8'h03);
    waitFall("03 start");
    rxFrame(8'h03, 1'b0, 1'b1, "f03", gap);
`endif

    // 6) Fifo reports data but cannot ack
    repeat (3) @(negedge clk);
    r0 = reqCount;
    p0 = popCnt;
    fakeNotEmpty = 1'b1;
    @(negedge clk);
    fakeNotEmpty = 1'b0;
    check(32'(fifoReadReq), 32'd1, "noack req");
    @(negedge clk);
    check(32'(fifoReadAck), 32'd0, "noack ack low");
    @(negedge clk);
    check(32'(busy), 32'd0, "noack back to idle");
    check(32'(txd), 32'd1, "noack txd high");
    lows = 0;
    repeat (30) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    check(32'(lows), 32'd0, "noack no frame");
    check(reqCount - r0, 32'd1, "noack single req");
    check(popCnt - p0, 32'd0, "noack no pop");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
